// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD initialisation sequencer.
package lcd_pkg;

   typedef enum logic [2:0] {
      RST_LOW,
      RST_WAIT,
      LOAD,
      SEND,
      DELAY,
      DONE
   } state_t;

   localparam int          LCD_INIT_LEN = 85;
   localparam logic [7:0]  CMD_SLPOUT   = 8'h11;
   localparam logic [7:0]  CMD_DISPON   = 8'h29;

endpackage

// File: rtl/lcd_delay_cnt.sv
// Wait counter shared by the reset-low, reset-wait and post-SLPOUT delays.
// tc is high on the cycle the count equals lim while enabled, so a wait of
// N cycles uses lim = N-1 and a counter cleared on state entry.
module lcd_delay_cnt #(
   parameter int DLY_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [DLY_W-1:0] lim,
   output logic             tc
);

   logic [DLY_W-1:0] cnt;

   // Count up while enabled; clear restarts the wait from zero
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + DLY_W'(1);
      end
   end

   assign tc = en && (cnt == lim);

endmodule

// File: rtl/lcd_init_seq.sv
// LCD init sequencer: panel reset, ROM walk to the SPI byte engine with a
// settle delay after SLPOUT, then pass-through of the pixel stream.
module lcd_init_seq
   import lcd_pkg::*;
#(
   parameter int ROM_LEN         = LCD_INIT_LEN,
   parameter int SLPOUT_ADDR     = 0,
   parameter int RST_LOW_CYC     = 1000,
   parameter int RST_WAIT_CYC    = 120000,
   parameter int SLPOUT_WAIT_CYC = 6000000,
   parameter int DLY_W           = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [15:0] rom_addr,
   input  logic [7:0]  rom_data,
   input  logic        rom_dc,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_dc,
   input  logic        tx_ready,
   input  logic        pix_valid,
   input  logic [7:0]  pix_data,
   output logic        pix_ready,
   output logic        lcd_rst_n,
   output logic        init_done
);

   localparam logic [DLY_W-1:0] LIM_LOW  = DLY_W'(RST_LOW_CYC - 1);
   localparam logic [DLY_W-1:0] LIM_WAIT = DLY_W'(RST_WAIT_CYC - 1);
   localparam logic [DLY_W-1:0] LIM_SLP  = DLY_W'(SLPOUT_WAIT_CYC - 1);
   localparam logic [15:0]      ADDR_LAST = 16'(ROM_LEN - 1);
   localparam logic [15:0]      ADDR_SLP  = 16'(SLPOUT_ADDR);

   state_t           state;
   logic             seq_valid;
   logic [7:0]       seq_data;
   logic             seq_dc;
   logic             counting;
   logic             dly_clr;
   logic             dly_tc;
   logic [DLY_W-1:0] dly_lim;

   // Pick the wait length for the current state; the counter sits at zero
   // outside the waiting states so each wait starts from a clean count
   always_comb begin
      counting = (state == RST_LOW) || (state == RST_WAIT) || (state == DELAY);
      case (state)
         RST_LOW:  dly_lim = LIM_LOW;
         RST_WAIT: dly_lim = LIM_WAIT;
         default:  dly_lim = LIM_SLP;
      endcase
   end

   assign dly_clr = !counting || dly_tc;

   lcd_delay_cnt #(.DLY_W(DLY_W)) u_dly (
      .clk (clk),
      .rst (rst),
      .clr (dly_clr),
      .en  (counting),
      .lim (dly_lim),
      .tc  (dly_tc)
   );

   // Sequencer FSM with registered ROM-side outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RST_LOW;
         rom_addr  <= '0;
         seq_valid <= 1'b0;
         seq_data  <= 8'h00;
         seq_dc    <= 1'b0;
         lcd_rst_n <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            RST_LOW: begin
               if (dly_tc) begin
                  lcd_rst_n <= 1'b1;
                  state     <= RST_WAIT;
               end
            end
            RST_WAIT: begin
               if (dly_tc) begin
                  rom_addr <= '0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               seq_data  <= rom_data;
               seq_dc    <= rom_dc;
               seq_valid <= 1'b1;
               state     <= SEND;
            end
            SEND: begin
               if (tx_ready) begin
                  seq_valid <= 1'b0;
                  if (rom_addr == ADDR_SLP) begin
                     state <= DELAY;
                  end else if (rom_addr == ADDR_LAST) begin
                     init_done <= 1'b1;
                     state     <= DONE;
                  end else begin
                     rom_addr <= rom_addr + 16'd1;
                     state    <= LOAD;
                  end
               end
            end
            DELAY: begin
               if (dly_tc) begin
                  if (rom_addr == ADDR_LAST) begin
                     init_done <= 1'b1;
                     state     <= DONE;
                  end else begin
                     rom_addr <= rom_addr + 16'd1;
                     state    <= LOAD;
                  end
               end
            end
            DONE: begin
               // A start pulse replays the whole init from a reset state
               if (start) begin
                  state     <= RST_LOW;
                  rom_addr  <= '0;
                  seq_valid <= 1'b0;
                  seq_data  <= 8'h00;
                  seq_dc    <= 1'b0;
                  lcd_rst_n <= 1'b0;
                  init_done <= 1'b0;
               end
            end
            default: begin
               state <= RST_LOW;
            end
         endcase
      end
   end

   // Output mux: the pixel source owns the transmitter only once init is done
   always_comb begin
      if (state == DONE) begin
         tx_valid  = pix_valid;
         tx_data   = pix_data;
         tx_dc     = 1'b1;
         pix_ready = tx_ready;
      end else begin
         tx_valid  = seq_valid;
         tx_data   = seq_data;
         tx_dc     = seq_dc;
         pix_ready = 1'b0;
      end
   end

endmodule

// File: tb/tb_lcd_init_seq.sv
// Scoreboard bench for lcd_init_seq with short wait parameters.
module tb_lcd_init_seq;

   localparam int RLOW  = 4;
   localparam int RWAIT = 6;
   localparam int SWAIT = 10;
   localparam int LEN   = 85;
   localparam int SLP   = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        tx_ready = 1'b1;
   logic        pix_valid = 1'b0;
   logic [7:0]  pix_data = 8'h00;
   logic [15:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_dc;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_dc;
   logic        pix_ready;
   logic        lcd_rst_n;
   logic        init_done;

   logic [7:0]  rom_b [LEN];
   logic        rom_f [LEN];

   typedef struct {
      logic [7:0] data;
      logic       dc;
      int         cyc;
   } xfer_t;

   xfer_t exp_q[$];
   xfer_t mon_e;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int t0 = 0;
   bit hold = 1'b0;
   logic [7:0] hold_data = 8'h00;
   logic       hold_dc = 1'b0;

   lcd_init_seq #(
      .ROM_LEN(LEN), .SLPOUT_ADDR(SLP), .RST_LOW_CYC(RLOW),
      .RST_WAIT_CYC(RWAIT), .SLPOUT_WAIT_CYC(SWAIT), .DLY_W(24)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr),
      .rom_data(rom_data), .rom_dc(rom_dc), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_dc(tx_dc), .tx_ready(tx_ready),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .lcd_rst_n(lcd_rst_n), .init_done(init_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Combinational command ROM image
   always_comb begin
      rom_data = 8'hFF;
      rom_dc   = 1'b1;
      if (rom_addr < 16'(LEN)) begin
         rom_data = rom_b[rom_addr[6:0]];
         rom_dc   = rom_f[rom_addr[6:0]];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
      chk({tag, "_tx_data"}, 32'(tx_data), 0);
      chk({tag, "_tx_dc"}, 32'(tx_dc), 0);
      chk({tag, "_lcd_rst_n"}, 32'(lcd_rst_n), 0);
      chk({tag, "_init_done"}, 32'(init_done), 0);
      chk({tag, "_pix_ready"}, 32'(pix_ready), 0);
      chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
   endtask

   // Reference: ROM bytes in address order; with tx_ready held high each
   // byte costs 2 cycles, plus the settle wait after the SLPOUT byte
   task automatic push_rom(input int count, input bit timed, output int last_cyc);
      int c;
      c = RLOW + RWAIT + 1;
      last_cyc = c;
      for (int k = 0; k < count; k++) begin
         exp_q.push_back('{data: rom_b[k], dc: rom_f[k], cyc: (timed ? c : -1)});
         last_cyc = c;
         c += (k == SLP) ? (SWAIT + 2) : 2;
      end
   endtask

   // Monitor: pop and compare on every handshake, plus protocol invariants
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_xfer: got data 0x%0h dc %0d, required no transfer", tx_data, tx_dc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("xfer_data", 32'(tx_data), 32'(mon_e.data));
               chk("xfer_dc", 32'(tx_dc), 32'(mon_e.dc));
               if (mon_e.cyc >= 0) chk("xfer_cycle", 32'(cyc - t0), 32'(mon_e.cyc));
            end
         end
         if (init_done !== 1'b1) chk("pix_ready_before_done", 32'(pix_ready), 0);
         if (lcd_rst_n === 1'b0) chk("no_tx_in_panel_reset", 32'(tx_valid), 0);
         if (hold) begin
            chk("hold_valid", 32'(tx_valid), 1);
            chk("hold_data", 32'(tx_data), 32'(hold_data));
            chk("hold_dc", 32'(tx_dc), 32'(hold_dc));
         end
         hold      = (tx_valid === 1'b1) && (tx_ready === 1'b0) && (init_done === 1'b0);
         hold_data = tx_data;
         hold_dc   = tx_dc;
      end else begin
         hold = 1'b0;
      end
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int  last;
      int  n;
      bit  bp_done;

      for (int i = 0; i < LEN; i++) begin
         rom_b[i] = 8'($urandom_range(0, 255));
         rom_f[i] = 1'($urandom_range(0, 1));
      end
      rom_b[0]  = 8'h11; rom_f[0]  = 1'b0;
      rom_b[1]  = 8'hB1; rom_f[1]  = 1'b0;
      rom_b[2]  = 8'h05; rom_f[2]  = 1'b1;
      rom_b[83] = 8'h29; rom_f[83] = 1'b0;
      rom_b[84] = 8'h2C; rom_f[84] = 1'b0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");

      // Run 1: full sequence, tx_ready high, pixel source active before DONE
      pix_valid = 1'b1;
      pix_data  = 8'h5A;
      @(posedge clk); #1;
      rst = 1'b0;
      t0  = cyc;
      push_rom(LEN, 1'b1, last);
      for (int i = 0; i <= last + 1; i++) begin
         @(negedge clk);
         if (i < RLOW) chk("rst_n_low", 32'(lcd_rst_n), 0);
         if (i == RLOW) chk("rst_n_high", 32'(lcd_rst_n), 1);
         if (i == RLOW + RWAIT + 1) begin
            chk("first_valid", 32'(tx_valid), 1);
            chk("first_data", 32'(tx_data), 32'h11);
            chk("first_dc", 32'(tx_dc), 0);
         end
         if (i > RLOW + RWAIT + 1 && i < RLOW + RWAIT + SWAIT + 3)
            chk("slpout_gap", 32'(tx_valid), 0);
         if (i == RLOW + RWAIT + SWAIT + 3) begin
            chk("second_valid", 32'(tx_valid), 1);
            chk("second_data", 32'(tx_data), 32'hB1);
         end
         if (i == last) chk("done_not_yet", 32'(init_done), 0);
         if (i == last + 1) begin
            chk("done_rise", 32'(init_done), 1);
            chk("done_addr", 32'(rom_addr), 32'(LEN - 1));
         end
         if (i == 100) pix_valid = 1'b0;
      end

      // Pass-through in DONE
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         pix_valid = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
         pix_data  = (i < 8) ? 8'hA5 : 8'($urandom_range(0, 255));
         tx_ready  = (i < 8) ? 1'(i % 2) : 1'($urandom_range(0, 1));
         if (pix_valid && tx_ready)
            exp_q.push_back('{data: pix_data, dc: 1'b1, cyc: -1});
         @(negedge clk);
         chk("pt_valid", 32'(tx_valid), 32'(pix_valid));
         chk("pt_data", 32'(tx_data), 32'(pix_data));
         chk("pt_dc", 32'(tx_dc), 1);
         chk("pt_ready", 32'(pix_ready), 32'(tx_ready));
      end
      @(posedge clk); #1;
      pix_valid = 1'b0;
      tx_ready  = 1'b1;
      chk("run1_drained", 32'(exp_q.size()), 0);

      // Run 2: start pulse, random backpressure, held-off byte at address 2
      start = 1'b1;
      push_rom(LEN, 1'b0, last);
      @(posedge clk); #1;
      start = 1'b0;
      t0    = cyc;
      @(negedge clk);
      chk("restart_rst_n", 32'(lcd_rst_n), 0);
      chk("restart_done", 32'(init_done), 0);
      chk("restart_pix_ready", 32'(pix_ready), 0);
      bp_done = 1'b0;
      n = 0;
      while (init_done !== 1'b1 && n < 3000) begin
         @(posedge clk); #1;
         n++;
         pix_valid = (rom_addr < 16'd80);
         pix_data  = 8'($urandom_range(0, 255));
         if (!bp_done && rom_addr == 16'd2 && tx_valid === 1'b1) begin
            tx_ready = 1'b0;
            for (int j = 0; j < 5; j++) begin
               @(negedge clk);
               chk("bp_addr", 32'(rom_addr), 2);
               chk("bp_data", 32'(tx_data), 32'h05);
               chk("bp_dc", 32'(tx_dc), 1);
               chk("bp_valid", 32'(tx_valid), 1);
               @(posedge clk); #1;
            end
            bp_done = 1'b1;
         end
         tx_ready = ($urandom_range(0, 3) != 0);
      end
      chk("run2_done", 32'(init_done), 1);
      chk("bp_seen", 32'(bp_done), 1);
      pix_valid = 1'b0;
      tx_ready  = 1'b1;
      @(posedge clk); #1;
      chk("run2_drained", 32'(exp_q.size()), 0);
      chk("run2_addr", 32'(rom_addr), 32'(LEN - 1));

      // Run 3: rst during the SLPOUT delay, then a clean replay
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t0    = cyc;
      exp_q.push_back('{data: 8'h11, dc: 1'b0, cyc: RLOW + RWAIT + 1});
      for (int i = 0; i <= 15; i++) @(negedge clk);
      chk("pre_rst_held_data", 32'(tx_data), 32'h11);
      chk("pre_rst_rst_n", 32'(lcd_rst_n), 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      t0  = cyc;
      chk("midrst_drained", 32'(exp_q.size()), 0);
      push_rom(2, 1'b1, last);
      for (int i = 0; i <= last + 1; i++) @(negedge clk);
      @(posedge clk); #1;
      chk("replay_drained", 32'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
